// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-writable single-port RAM.
//   ram_state_t  : clear-sequencer / request FSM states
//   nbytes()     : number of byte lanes in a word
//   even_parity(): even-parity bit of one lane (lane zero-extended to MAX_BYTE_W)
package ram_pkg;

    typedef enum logic {
        RS_INIT  = 1'b0,
        RS_READY = 1'b1
    } ram_state_t;

    localparam int MAX_BYTE_W = 64;

    function automatic int nbytes(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

    // Returns the bit that makes lane+parity contain an even number of ones.
    function automatic logic even_parity(input logic [MAX_BYTE_W-1:0] lane);
        return ^lane;
    endfunction

endpackage

// File: rtl/ram_bw_array.sv
// Storage array with per-lane write enables and a single registered read port.
//   clk, rst_n  : clock, async active-low reset (read register only; storage is not reset)
//   wr_en       : write the enabled lanes of wr_data to mem[addr]
//   addr        : word address shared by read and write
//   wr_be       : lane enables for the write
//   wr_data     : write data
//   wr_inject   : invert stored parity of enabled lanes (parity build only)
//   rd_en       : capture mem[addr] into rdata
//   rd_zero     : capture zero into rdata (out-of-range read)
//   rdata       : registered read data, holds when neither rd_en nor rd_zero
//   rd_perr     : parity mismatch on the word captured by the last cycle's read
// Optional feature: RAM_PARITY_EN adds one even-parity bit per lane.
module ram_bw_array
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    localparam int NB        = nbytes(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [NB-1:0]         wr_be,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_inject,
    input  logic                  rd_en,
    input  logic                  rd_zero,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rd_perr
);

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem_q[addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Reading mem_q here sees a write made on the previous edge, which gives
    // back-to-back read-after-write the new data without a bypass path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= mem_q[addr];
        end else if (rd_zero) begin
            rdata_q <= '0;
        end
    end

    assign rdata = rdata_q;

`ifdef RAM_PARITY_EN
    logic [NB-1:0] par_q [RAM_DEPTH];
    logic [NB-1:0] par_mism;
    logic          perr_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    par_q[addr][i] <= even_parity(MAX_BYTE_W'(wr_data[i*BYTE_WIDTH +: BYTE_WIDTH]))
                                      ^ wr_inject;
                end
            end
        end
    end

    always_comb begin
        par_mism = '0;
        for (int i = 0; i < NB; i++) begin
            par_mism[i] = even_parity(MAX_BYTE_W'(mem_q[addr][i*BYTE_WIDTH +: BYTE_WIDTH]))
                          ^ par_q[addr][i];
        end
    end

    // Cleared on every non-read cycle so the flag only ever accompanies a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= rd_en & (|par_mism);
        end
    end

    assign rd_perr = perr_q;
`else
    logic unused_inject;
    assign unused_inject = wr_inject;
    assign rd_perr       = 1'b0;
`endif

endmodule

// File: rtl/ram_sp_bw_init.sv
// Single-port synchronous RAM with valid/ready requests, byte-lane writes,
// 1-cycle registered read response and a clear sequencer that fills the
// array with INIT_VALUE after reset or on init_start.
//   clk, rst_n        : clock, async active-low reset
//   init_start / busy : request a full clear (honoured in READY) / clear in progress
//   req_*             : request channel (valid/ready, we, addr, be, wdata)
//   rsp_valid/rdata   : read response, one pulse per accepted read; rdata holds otherwise
//   err_inject        : corrupt stored parity of the written lanes (parity build only)
//   parity_err        : parity mismatch flagged alongside rsp_valid
// Optional feature: RAM_PARITY_EN (per-lane even parity); otherwise parity_err=0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RS_INIT  | clear sequencer writes INIT_VALUE to mem[cnt], one word/cycle
// RS_READY | requests accepted, one per cycle
module ram_sp_bw_init
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH                  = 32,
    parameter int BYTE_WIDTH                  = 8,
    parameter int ADDR_WIDTH                  = 8,
    parameter int RAM_DEPTH                   = 1 << ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    localparam int NB                         = nbytes(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_start,
    output logic                  busy,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [NB-1:0]         req_be,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    input  logic                  err_inject,
    output logic                  parity_err
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(RAM_DEPTH);

    ram_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rsp_valid_q;

    logic                  accept;
    logic                  in_range;
    logic                  arr_wr_en;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [NB-1:0]         arr_be;
    logic [DATA_WIDTH-1:0] arr_wdata;
    logic                  arr_inject;
    logic                  arr_rd_en;
    logic                  arr_rd_zero;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RS_INIT: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = RS_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RS_READY: begin
                if (init_start) begin
                    state_d = RS_INIT;
                end
            end
            default: begin
                state_d = RS_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RS_INIT;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= accept & ~req_we;
        end
    end

    assign busy      = (state_q == RS_INIT);
    assign req_ready = (state_q == RS_READY);
    assign accept    = req_valid & req_ready;
    assign in_range  = ({1'b0, req_addr} < DEPTH_W);

    // The sequencer owns the array port in INIT; requests own it in READY.
    assign arr_wr_en   = busy | (accept & req_we & in_range);
    assign arr_addr    = busy ? cnt_q : req_addr;
    assign arr_be      = busy ? {NB{1'b1}} : req_be;
    assign arr_wdata   = busy ? INIT_VALUE : req_wdata;
    assign arr_inject  = ~busy & err_inject;
    assign arr_rd_en   = accept & ~req_we & in_range;
    assign arr_rd_zero = accept & ~req_we & ~in_range;

    ram_bw_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAM_DEPTH  (RAM_DEPTH)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (arr_wr_en),
        .addr      (arr_addr),
        .wr_be     (arr_be),
        .wr_data   (arr_wdata),
        .wr_inject (arr_inject),
        .rd_en     (arr_rd_en),
        .rd_zero   (arr_rd_zero),
        .rdata     (rsp_rdata),
        .rd_perr   (parity_err)
    );

    assign rsp_valid = rsp_valid_q;

endmodule
